fft_frame_packer: RTL and testbench

Capture-side framer for the FFT path. Collects real audio samples from the acquisition front end into a ping-pong pair of FFT_SIZE-deep buffers. Each completed frame goes out as one AXI-Stream packet of complex words, in the format the FFT core's stream input consumes. Each packet is preceded by a one-cycle fft_go pulse that launches the FFT. The block sits between the audio sample source and fft_wrapper's s_axis port, and is the transmitting end of that stream.

---
 rtl/fft_frame_packer.sv | 206 ++++++++++++++++++++
 tb/tb_fft_frame_packer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_packer.sv
// Ping-pong framer: real audio samples -> AXI-Stream packets of complex words for the FFT.
// Latency: bank READY 1 cycle after last strobe, fft_go 1 cycle later, first beat 2 cycles after fft_go.
// Backpressure: tready stalls the output skid; samples are dropped (and counted) when no bank is free.
module fft_frame_packer #(
  parameter int FFT_SIZE     = 4096,
  parameter int DATA_WIDTH   = 64,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture_en,
  input  logic                      sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]   sample_data,
  output logic                      fft_go,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [15:0]               overflow_count,
  output logic                      packer_busy
);

  localparam int AW = $clog2(FFT_SIZE);
  localparam int HW = DATA_WIDTH / 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_SIZE - 1);

  typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_READY, BANK_SENDING} bank_t;
  typedef enum logic [1:0] {RD_IDLE, RD_GO, RD_STREAM} rd_state_t;

  // Bank bookkeeping and write side
  bank_t           bank_state [2];
  logic            wr_bank;
  logic [AW-1:0]   wr_idx;

  // Read side
  rd_state_t       rd_state;
  logic            rd_bank;
  logic [AW-1:0]   rd_addr;
  logic            rd_all_issued;
  logic            rd_issue;

  // Storage and the BRAM output stage
  logic [DATA_WIDTH-1:0] mem0 [FFT_SIZE];
  logic [DATA_WIDTH-1:0] mem1 [FFT_SIZE];
  logic [DATA_WIDTH-1:0] rd_dat0, rd_dat1, rd_dat;
  logic                  rd_vld, rd_last;

  // Output register plus one spare entry form the 2-entry skid
  logic                  out_vld, out_last;
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  skid_vld, skid_last;
  logic [DATA_WIDTH-1:0] skid_dat;

  logic [HW-1:0]         sample_ext;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  pop, tlast_xfer, free_now;
  logic                  wr_bank_open, strobe, wr_en, drop;
  logic [2:0]            inflight;

  assign sample_ext = HW'($signed(sample_data));
  assign wr_word    = {sample_ext, {HW{1'b0}}};

  assign pop        = out_vld & m_axis_tready;
  assign tlast_xfer = pop & out_last;
  // Reader releases its bank on the tlast transfer; the writer may use it in that same cycle.
  assign free_now   = (rd_state == RD_STREAM) & tlast_xfer;

  assign wr_bank_open = (bank_state[wr_bank] == BANK_FREE) ||
                        (bank_state[wr_bank] == BANK_FILLING) ||
                        (free_now && (rd_bank == wr_bank));
  assign strobe = sample_valid & capture_en;
  assign wr_en  = strobe & wr_bank_open;
  assign drop   = strobe & ~wr_bank_open;

  // Entries held in the BRAM stage and skid after this cycle's pop; a read may issue only if it fits.
  assign inflight = 3'(out_vld) + 3'(skid_vld) + 3'(rd_vld) - 3'(pop);
  assign rd_issue = (rd_state == RD_GO) ||
                    ((rd_state == RD_STREAM) && !rd_all_issued && (inflight < 3'd2));

  assign rd_dat = rd_bank ? rd_dat1 : rd_dat0;

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_dat;
  assign m_axis_tlast  = out_last;
  assign m_axis_tkeep  = '1;
  assign packer_busy   = (bank_state[0] == BANK_READY) || (bank_state[0] == BANK_SENDING) ||
                         (bank_state[1] == BANK_READY) || (bank_state[1] == BANK_SENDING);

  // Bank storage: one write port and one synchronous read port per bank
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) mem0[wr_idx] <= wr_word;
    if (wr_en &&  wr_bank) mem1[wr_idx] <= wr_word;
    if (rd_issue) begin
      rd_dat0 <= mem0[rd_addr];
      rd_dat1 <= mem1[rd_addr];
    end
  end

  // Bank states, write pointer/index and drop counter; writer updates take priority over reader frees
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_state[0]  <= BANK_FREE;
      bank_state[1]  <= BANK_FREE;
      wr_bank        <= 1'b0;
      wr_idx         <= '0;
      overflow_count <= '0;
    end else begin
      if (rd_state == RD_GO) bank_state[rd_bank] <= BANK_SENDING;
      if (free_now)          bank_state[rd_bank] <= BANK_FREE;
      if (!capture_en) begin
        // Partial frame is discarded; the bank stays owned by the writer
        wr_idx <= '0;
      end else if (wr_en) begin
        if (wr_idx == LAST_IDX) begin
          bank_state[wr_bank] <= BANK_READY;
          wr_idx              <= '0;
          wr_bank             <= ~wr_bank;
        end else begin
          bank_state[wr_bank] <= BANK_FILLING;
          wr_idx              <= wr_idx + 1'b1;
        end
      end
      if (drop && (overflow_count != 16'hFFFF)) overflow_count <= overflow_count + 16'd1;
    end
  end

  // Read FSM: launch pulse, then issue addresses in order as skid space allows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state      <= RD_IDLE;
      rd_bank       <= 1'b0;
      rd_addr       <= '0;
      rd_all_issued <= 1'b0;
      fft_go        <= 1'b0;
    end else begin
      fft_go <= 1'b0;
      if (rd_issue) begin
        rd_addr <= rd_addr + 1'b1;
        if (rd_addr == LAST_IDX) rd_all_issued <= 1'b1;
      end
      case (rd_state)
        RD_IDLE: begin
          rd_addr       <= '0;
          rd_all_issued <= 1'b0;
          if (bank_state[rd_bank] == BANK_READY) begin
            rd_state <= RD_GO;
            fft_go   <= 1'b1;
          end
        end
        RD_GO: rd_state <= RD_STREAM;
        RD_STREAM: begin
          if (tlast_xfer) begin
            rd_state <= RD_IDLE;
            rd_bank  <= ~rd_bank;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // BRAM output stage valid/last tracking, aligned with rd_dat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_vld  <= rd_issue;
      rd_last <= rd_issue && (rd_addr == LAST_IDX);
    end
  end

  // Output register with a spare entry so read data already in flight is never lost on a stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_dat   <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      skid_dat  <= '0;
    end else if (!out_vld || pop) begin
      if (skid_vld) begin
        out_vld   <= 1'b1;
        out_last  <= skid_last;
        out_dat   <= skid_dat;
        skid_vld  <= rd_vld;
        skid_last <= rd_last;
        skid_dat  <= rd_dat;
      end else if (rd_vld) begin
        out_vld  <= 1'b1;
        out_last <= rd_last;
        out_dat  <= rd_dat;
      end else begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end
    end else if (rd_vld) begin
      skid_vld  <= 1'b1;
      skid_last <= rd_last;
      skid_dat  <= rd_dat;
    end
  end

endmodule

// File: tb/tb_fft_frame_packer.sv
// Bench for fft_frame_packer with FFT_SIZE=8: table-driven frame contents plus directed
// sequences for launch timing, overflow, random backpressure, capture gating and mid-frame reset.
module tb_fft_frame_packer;
  localparam int N  = 8;
  localparam int DW = 64;
  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          capture_en = 1'b0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          fft_go;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [15:0]   overflow_count;
  logic          packer_busy;

  fft_frame_packer #(.FFT_SIZE(N), .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .sample_valid(sample_valid),
    .sample_data(sample_data), .fft_go(fft_go), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .overflow_count(overflow_count), .packer_busy(packer_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic last; logic [DW-1:0] dat;} beat_t;
  typedef struct {logic [SW-1:0] smp; logic [DW-1:0] exp_dat; logic exp_last;} vec_t;

  int    n_checks = 0;
  int    n_fail = 0;
  int    go_count = 0;
  int    last_count = 0;
  beat_t beats[$];
  beat_t exp_q[$];
  logic  rand_ready = 1'b0;
  logic  stall_q = 1'b0;
  beat_t stall_beat;
  vec_t  tbl[16];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [SW-1:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] word_of(input logic [SW-1:0] v);
    return {{(DW/2-SW){v[SW-1]}}, v, {(DW/2){1'b0}}};
  endfunction

  task automatic expect_frame(input int base);
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N-1), word_of(SW'(base + i))});
  endtask

  // Wait (bounded) for all expected beats, then compare contents, order and tlast
  task automatic compare_all(input string name, input int budget);
    int waited = 0;
    while ((beats.size() < exp_q.size()) && (waited < budget)) begin
      tick();
      waited++;
    end
    repeat (4) tick();
    check({name, "_beat_count"}, DW'(beats.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < beats.size()) begin
        check({name, "_tdata"}, beats[i].dat, exp_q[i].dat);
        check({name, "_tlast"}, DW'(beats[i].last), DW'(exp_q[i].last));
      end
    end
    beats.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    beats.delete();
    exp_q.delete();
    go_count = 0;
    last_count = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_fft_go"}, DW'(fft_go), 0);
    check({name, "_tvalid"}, DW'(m_axis_tvalid), 0);
    check({name, "_tlast"}, DW'(m_axis_tlast), 0);
    check({name, "_tdata"}, m_axis_tdata, 0);
    check({name, "_tkeep"}, DW'(m_axis_tkeep), DW'(8'hFF));
    check({name, "_overflow"}, DW'(overflow_count), 0);
    check({name, "_busy"}, DW'(packer_busy), 0);
  endtask

  // Output monitor: records transfers, counts pulses, and checks hold-while-stalled
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_tvalid", DW'(m_axis_tvalid), 1);
        check("hold_tdata", m_axis_tdata, stall_beat.dat);
        check("hold_tlast", DW'(m_axis_tlast), DW'(stall_beat.last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back({m_axis_tlast, m_axis_tdata});
        if (m_axis_tlast) last_count++;
        check("beat_tkeep", DW'(m_axis_tkeep), DW'(8'hFF));
      end
      if (fft_go) go_count++;
      stall_q    = m_axis_tvalid && !m_axis_tready;
      stall_beat = {m_axis_tlast, m_axis_tdata};
    end
  end

  // Random backpressure source, active only when enabled
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    for (int i = 0; i < N; i++) tbl[i] = '{SW'(i + 1), {32'(i + 1), 32'd0}, (i == N-1)};
    tbl[8]  = '{24'h800000, 64'hFF800000_00000000, 1'b0};
    tbl[9]  = '{24'h7FFFFF, 64'h007FFFFF_00000000, 1'b0};
    tbl[10] = '{24'hFFFFFF, 64'hFFFFFFFF_00000000, 1'b0};
    tbl[11] = '{24'h000000, 64'h00000000_00000000, 1'b0};
    tbl[12] = '{24'hABCDEF, 64'hFFABCDEF_00000000, 1'b0};
    tbl[13] = '{24'h123456, 64'h00123456_00000000, 1'b0};
    tbl[14] = '{24'h400000, 64'h00400000_00000000, 1'b0};
    tbl[15] = '{24'hC00001, 64'hFFC00001_00000000, 1'b1};

    // Reset state
    @(negedge clk);
    check_reset_outputs("reset");
    do_reset();

    // Table frames with launch timing on the first
    capture_en    = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) feed(tbl[i].smp);
    check("ready_busy", DW'(packer_busy), 1);
    check("go_not_yet", DW'(fft_go), 0);
    tick();
    check("go_pulse", DW'(fft_go), 1);
    tick();
    check("go_one_cycle", DW'(fft_go), 0);
    check("tvalid_not_yet", DW'(m_axis_tvalid), 0);
    tick();
    check("first_tdata", m_axis_tdata, tbl[0].exp_dat);
    for (int i = 0; i < N; i++) begin
      check("no_bubble_tvalid", DW'(m_axis_tvalid), 1);
      check("tlast_position", DW'(m_axis_tlast), DW'(i == N-1));
      tick();
    end
    for (int i = N; i < 2*N; i++) feed(tbl[i].smp);
    for (int i = 0; i < 2*N; i++) exp_q.push_back({tbl[i].exp_last, tbl[i].exp_dat});
    compare_all("table", 200);
    check("table_go_count", DW'(go_count), 2);

    // Overflow with tready held low
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3*N; i++) feed(SW'(100 + i));
    check("ovf_count", DW'(overflow_count), 8);
    repeat (20) tick();
    check("ovf_no_transfer", DW'(beats.size()), 0);
    check("ovf_tvalid_held", DW'(m_axis_tvalid), 1);
    check("ovf_busy", DW'(packer_busy), 1);
    m_axis_tready = 1'b1;
    expect_frame(100);
    expect_frame(108);
    compare_all("ovf", 200);
    check("ovf_go_count", DW'(go_count), 2);
    check("ovf_count_kept", DW'(overflow_count), 8);

    // Four frames under random backpressure, never more than one frame pending
    do_reset();
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      waited = 0;
      while ((beats.size() < N*(f-1)) && (waited < 300)) begin
        tick();
        waited++;
      end
      for (int i = 0; i < N; i++) feed(SW'(200 + N*f + i));
      expect_frame(200 + N*f);
    end
    compare_all("rand", 600);
    rand_ready = 1'b0;
    tick();
    tick();
    m_axis_tready = 1'b1;
    check("rand_go_count", DW'(go_count), 4);
    check("rand_last_count", DW'(last_count), 4);
    check("rand_ovf", DW'(overflow_count), 0);

    // Capture gating discards a partial frame without counting drops
    do_reset();
    for (int i = 0; i < 5; i++) feed(SW'(500 + i));
    capture_en = 1'b0;
    for (int i = 0; i < 3; i++) feed(SW'(550 + i));
    capture_en = 1'b1;
    for (int i = 0; i < N; i++) feed(SW'(600 + i));
    expect_frame(600);
    compare_all("capen", 200);
    check("capen_ovf", DW'(overflow_count), 0);
    check("capen_go_count", DW'(go_count), 1);

    // Reset in the middle of a packet, then a clean frame from B0
    do_reset();
    for (int i = 0; i < N; i++) feed(SW'(700 + i));
    waited = 0;
    while ((beats.size() < 3) && (waited < 100)) begin
      tick();
      waited++;
    end
    check("midrst_reached_beat3", DW'(beats.size() >= 3), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_no_tlast", DW'(last_count), 0);
    tick();
    reset = 1'b0;
    tick();
    beats.delete();
    go_count = 0;
    last_count = 0;
    for (int i = 0; i < N; i++) feed(SW'(800 + i));
    expect_frame(800);
    compare_all("postrst", 200);
    check("postrst_go_count", DW'(go_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
